// File: rtl/toy_mem_req_adapter.sv
// rtl/toy_mem_req_adapter.sv - request/response adapter in front of a one-cycle-latency memory
//
// Accepts requests on a valid/ready channel, issues them to a synchronous
// memory in the accept cycle, and returns one response per request, in order,
// through a small response FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_vld/req_rdy          request handshake
//   req_addr, req_wr_en      request address and direction
//   req_wr_data, req_wr_byte_en  write payload and byte lanes
//   rsp_vld/rsp_rdy          response handshake
//   rsp_data, rsp_is_wr      response payload (0 data for writes)
//   mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_wr_byte_en  memory command
//   mem_rd_data              memory read data, valid the cycle after mem_en
module toy_mem_req_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr_en,
  input  logic [DATA_WIDTH-1:0]   req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req_wr_byte_en,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_is_wr,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  output logic                    mem_wr_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_wr_q, pend_wr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [DATA_WIDTH-1:0] data_mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  is_wr_mem_q, is_wr_mem_d;

  logic [CNT_W:0]        inflight;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Ready counts the request sitting in the pending stage as well as the
  // buffered ones, so a FIFO slot is always reserved for every accepted
  // request. It deliberately ignores rsp_rdy to keep the path short.
  always_comb begin
    inflight = {1'b0, fifo_count_q} + {{CNT_W{1'b0}}, pend_vld_q};
    req_rdy  = ~rst & (inflight < (CNT_W+1)'(RSP_DEPTH));
    accept   = req_vld & req_rdy;
    rsp_vld  = (fifo_count_q != '0);
    push     = pend_vld_q;
    pop      = rsp_vld & rsp_rdy;
  end

  always_comb begin
    mem_en         = accept;
    mem_addr       = req_addr;
    mem_wr_en      = req_wr_en;
    mem_wr_data    = req_wr_data;
    mem_wr_byte_en = req_wr_byte_en;
    rsp_data       = data_mem_q[rd_ptr_q];
    rsp_is_wr      = is_wr_mem_q[rd_ptr_q];
  end

  always_comb begin
    pend_vld_d   = accept;
    pend_wr_d    = req_wr_en;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    data_mem_d   = data_mem_q;
    is_wr_mem_d  = is_wr_mem_q;

    if (push) begin
      // Write responses carry no data; the memory's read port is stale then.
      data_mem_d[wr_ptr_q]  = pend_wr_q ? '0 : mem_rd_data;
      is_wr_mem_d[wr_ptr_q] = pend_wr_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      is_wr_mem_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        data_mem_q[i] <= '0;
      end
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_wr_q    <= pend_wr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      is_wr_mem_q  <= is_wr_mem_d;
      data_mem_q   <= data_mem_d;
    end
  end

endmodule

// File: doc/toy_mem_req_adapter.md
TOY_MEM_REQ_ADAPTER -- requirements
Module: toy_mem_req_adapter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the request and memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width; it is a multiple of 8.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 4, meaning the response FIFO entry count; it is a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 The block SHALL have req_vld (input, 1), req_rdy (output, 1), req_addr (input, ADDR_WIDTH), req_wr_en (input, 1), req_wr_data (input, DATA_WIDTH) and req_wr_byte_en (input, DATA_WIDTH/8) as the request channel.
REQ-007 The block SHALL have rsp_vld (output, 1), rsp_rdy (input, 1), rsp_data (output, DATA_WIDTH) and rsp_is_wr (output, 1) as the response channel.
REQ-008 The block SHALL have mem_en, mem_addr, mem_wr_data, mem_wr_byte_en and mem_wr_en as outputs, and mem_rd_data (DATA_WIDTH) as input, forming the memory side; read data is valid the cycle after the access edge.

Function
REQ-009 The block SHALL treat a request as accepted in any cycle where req_vld and req_rdy are both 1.
REQ-010 The block SHALL drive mem_en equal to the accept condition in the same cycle.
- mem_addr, mem_wr_data, mem_wr_byte_en and mem_wr_en pass straight through from req_*.
- mem_en is 0 whenever no accept occurs.
REQ-011 The block SHALL register a pending stage on every accept: pend_vld=1, pend_wr=req_wr_en.
REQ-012 On the edge following an accept, the block SHALL push one FIFO entry while pend_vld=1:
- data = mem_rd_data for reads, 0 for writes; is_wr = pend_wr.
- For writes, mem_rd_data is never sampled, because the memory does not update read data on writes.
REQ-013 The block SHALL compute inflight = pend_vld + fifo_count, and drive req_rdy = (inflight < RSP_DEPTH) and not rst.
- req_rdy has no combinational dependence on rsp_rdy or req_vld.
REQ-014 The block SHALL drive rsp_vld = (fifo_count != 0), with rsp_data and rsp_is_wr taken from the FIFO head; the FIFO pops when rsp_vld and rsp_rdy are both 1.
REQ-015 The block SHALL give a minimum accept-to-rsp_vld latency of 2 cycles (accept in cycle N, rsp_vld in N+2).
REQ-016 The block SHALL keep responses in strict request order.
REQ-017 The block SHALL hold rsp_data and rsp_is_wr stable while rsp_vld=1 and rsp_rdy=0.
REQ-018 On a simultaneous push and pop, fifo_count SHALL be unchanged.
- A push into a full FIFO is impossible by REQ-013.
- With RSP_DEPTH>=3 and rsp_rdy held 1, sustained throughput is 1 request per cycle.
REQ-019 The FIFO read and write pointers SHALL be log2(RSP_DEPTH) bits wide and wrap modulo RSP_DEPTH.
- fifo_count is log2(RSP_DEPTH)+1 bits wide.

Reset
REQ-020 While rst=1, the block SHALL asynchronously force the following to 0: pend_vld, FIFO pointers, fifo_count, req_rdy, rsp_vld and mem_en.
- rsp_data and rsp_is_wr reset to 0.
REQ-021 An rst assertion mid-operation SHALL discard the pending and buffered responses; no response for those requests ever appears.
REQ-022 The block SHALL allow req_rdy to rise in the first cycle after rst deasserts.

Verification
REQ-023 Single read: memory word 0x10 = 0xDEADBEEF; read 0x10 accepted at cycle N -> mem_en=1 and mem_wr_en=0 at N; rsp_vld=1 at N+2 with rsp_data=0xDEADBEEF and rsp_is_wr=0.
REQ-024 Write then read: write 0x20 data 0x11223344 be=4'b0101, then read 0x20 -> first response is_wr=1 with data 0; second response data = 0xXX22XX44 merged with the prior contents.
REQ-025 Backpressure: rsp_rdy=0 with RSP_DEPTH=4 and continuous reads -> exactly 4 accepts, then req_rdy=0; rsp_data held stable; rsp_rdy=1 -> responses drain in order and req_rdy returns 1.
REQ-026 Streaming: 16 back-to-back reads with rsp_rdy=1 -> one accept per cycle, 16 in-order responses, no gaps after the first.
REQ-027 Reset mid-flight: assert rst with 3 requests outstanding -> rsp_vld, req_rdy and mem_en are 0 immediately; after release, no stale response appears and a new read returns correct data.
REQ-028 Wrap: more than 2*RSP_DEPTH requests with random rsp_rdy -> a scoreboard reports zero ordering or data mismatches.
